imem_responder: RTL and testbench
=================================

# imem_responder

Memory-side responder for the instruction/data memory valid/ready interface driven by the fetch stage and the load/store unit. It holds a word-organised synchronous RAM and accepts one request per cycle. It returns read data with `mem_ready_o` after a fixed, parameterised latency. It serves as the tightly-coupled instruction memory in the core testbench and the FPGA top level, and is the slave model the fetch stage is verified against.

## Interface
- `DEPTH_WORDS`, default 4096: RAM size in 32-bit words; power of two.
- `WAIT_STATES`, default 0: extra cycles between acceptance and response; legal range 0..7.
- `BASE_ADDR`, default 32'h0: byte address mapped to word 0.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_valid_i` in 1: request present.
- `mem_addr_i` in `RISCV_ADDR_WIDTH` (32): byte address; bits [1:0] ignored.
- `mem_wdata_i` in `RISCV_WORD_WIDTH` (32): write data.
- `mem_we_i` in 4: byte write enables; 4'b0000 means read.
- `mem_ready_o` out 1: response strobe; `mem_rdata_o` is valid this cycle.
- `mem_rdata_o` out 32: read data for the oldest accepted request.
- `mem_err_o` out 1: qualified by `mem_ready_o`; the request address was out of range.

## Operation
- States: IDLE, WAIT, RESP.
- Acceptance: a request is accepted in any cycle where `mem_valid_i`=1 and the FSM is in IDLE or RESP (pipelined: a new request is accepted in the same cycle as the previous response). No request is accepted in WAIT.
- On acceptance the block latches the word index ((addr − BASE_ADDR)>>2), wdata, we and range status. Changes to any input after acceptance have no effect on that request.
- Transitions for an accepted request:
  - WAIT_STATES=0: next state is RESP.
  - WAIT_STATES>0: next state is WAIT with counter = WAIT_STATES−1. WAIT decrements the counter each cycle and moves to RESP after the cycle where the counter is 0.
- RESP with no new acceptance returns to IDLE. RESP with a new acceptance follows the same transition rule as acceptance from IDLE.
- `mem_ready_o`=1 exactly in RESP, for one cycle per accepted request.
- Reads: `mem_rdata_o` = RAM[index] as stored before any write of the same request.
- Writes: bytes with `we[i]`=1 are updated in the RESP cycle (clock edge ending RESP). `mem_rdata_o` shows the pre-write word.
- Range: in range iff BASE_ADDR ≤ addr < BASE_ADDR + 4·DEPTH_WORDS, unsigned 32-bit compare with no wrap. Out of range gives `mem_err_o`=1, `mem_rdata_o`=0, and no write.
- Dropping `mem_valid_i` after acceptance does not cancel the request; its response is still delivered.

## Timing
- Reset values: `mem_ready_o`=0, `mem_rdata_o`=0, `mem_err_o`=0, state IDLE, counter 0. RAM contents are not reset.
- Latency: request accepted at edge N gives `mem_ready_o` high during cycle N+1+WAIT_STATES.
- Throughput:
  - WAIT_STATES=0: one word per cycle while `mem_valid_i` is held high.
  - Otherwise: one response per WAIT_STATES+1 cycles.
- `mem_ready_o`, `mem_rdata_o` and `mem_err_o` are registered outputs with no combinational path from the inputs. This is required because the fetch stage derives its next address combinationally from ready.
- Outside RESP, `mem_rdata_o` and `mem_err_o` hold 0.
- Reset asserted mid-WAIT or mid-RESP aborts the request: no response and no write. After release, the FSM is in IDLE.
- Address 32'hFFFFFFFC with BASE_ADDR=0 and default depth is out of range; no index wrap.

## Test plan
- Reset: assert `rst_n`=0 during a WAIT state. Required: all outputs 0 immediately (async). After release, no stale `mem_ready_o` pulse appears.
- Streaming read, WAIT_STATES=0: RAM[0..2] = 0x00000013, 0x00100093, 0x00200113. Hold valid with addr 0x0, then 0x4, then 0x8, each advanced on ready. Required: ready in cycles 1, 2, 3 with those words in order.
- Latency, WAIT_STATES=2: single read of 0x8, valid pulsed for one cycle. Required: ready exactly 3 cycles after acceptance with data 0x00200113. Changing addr to 0x0 during WAIT has no effect.
- Byte write: RAM[4] = 0x11223344; request addr 0x10, we=4'b0011, wdata=0xAABBCCDD. Required: response rdata=0x11223344. A following read of 0x10 returns 0x1122CCDD.
- Out of range, DEPTH_WORDS=16: read 0x40, then write 0x44 with we=4'hF. Required: each response has `mem_err_o`=1 and rdata=0, and RAM is unchanged.
- Back-to-back with WAIT_STATES=1: valid held high for addresses 0x0, 0x4, 0x8. Required: ready every second cycle, no request lost or duplicated, and the valid-drop-after-accept case still responds.

Source files
------------

// File: rtl/imem_responder_if.sv
// Valid/ready memory bus between a requester (fetch stage or LSU) and the memory responder.
interface imem_responder_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_we,
    input  mem_ready, mem_rdata, mem_err
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_we,
    output mem_ready, mem_rdata, mem_err
  );
endinterface

// File: rtl/imem_responder.sv
// Word-organised synchronous RAM responder with fixed, parameterised response latency.
// Accepts one request per cycle in IDLE/RESP; all response outputs are registered.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_responder_if.slave  mem
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic [31:0]   ram [DEPTH_WORDS];

  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    we_q;
  logic          ok_q;

  logic [31:0]   off;
  logic          in_ok;
  logic [AW-1:0] in_idx;
  logic          accept;
  logic [AW-1:0] rd_idx;
  logic          rd_ok;
  logic [31:0]   rd_word;

  logic          ready;
  logic [31:0]   rdata;
  logic          err;

  always_comb begin
    off    = mem.mem_addr - BASE_ADDR;
    in_ok  = (mem.mem_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    in_idx = off[AW+1:2];
    accept = mem.mem_valid && ((state == IDLE) || (state == RESP));
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_LOAD;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) state_n = RESP;
        else             cnt_n   = cnt - 3'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // With no wait states a new read is sampled on the same edge that retires the
  // previous write, so bytes being written to the same word are forwarded.
  always_comb begin
    rd_idx  = (state == WAIT) ? idx_q : in_idx;
    rd_ok   = (state == WAIT) ? ok_q  : in_ok;
    rd_word = ram[rd_idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if ((state == RESP) && ok_q && we_q[i] && (idx_q == rd_idx))
        rd_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      ok_q    <= 1'b0;
      ready   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        idx_q   <= in_idx;
        wdata_q <= mem.mem_wdata;
        we_q    <= mem.mem_we;
        ok_q    <= in_ok;
      end
      ready <= (state_n == RESP);
      rdata <= ((state_n == RESP) && rd_ok) ? rd_word : '0;
      err   <= (state_n == RESP) && !rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == RESP) && ok_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we_q[i]) ram[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign mem.mem_ready = ready;
  assign mem.mem_rdata = rdata;
  assign mem.mem_err   = err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances cover 0, 1 and 2 wait states
// and a small-depth configuration for range checks.
module tb_imem_responder;

  logic        clk;
  logic        rst_n;
  logic        v   [3];
  logic [31:0] a   [3];
  logic [31:0] wd  [3];
  logic [3:0]  we  [3];
  logic        rdy [3];
  logic [31:0] rd  [3];
  logic        er  [3];

  int total = 0;
  int bad   = 0;

  imem_responder_if bus0 ();
  imem_responder_if bus1 ();
  imem_responder_if bus2 ();

  assign bus0.mem_valid = v[0];
  assign bus0.mem_addr  = a[0];
  assign bus0.mem_wdata = wd[0];
  assign bus0.mem_we    = we[0];
  assign rdy[0] = bus0.mem_ready;
  assign rd[0]  = bus0.mem_rdata;
  assign er[0]  = bus0.mem_err;

  assign bus1.mem_valid = v[1];
  assign bus1.mem_addr  = a[1];
  assign bus1.mem_wdata = wd[1];
  assign bus1.mem_we    = we[1];
  assign rdy[1] = bus1.mem_ready;
  assign rd[1]  = bus1.mem_rdata;
  assign er[1]  = bus1.mem_err;

  assign bus2.mem_valid = v[2];
  assign bus2.mem_addr  = a[2];
  assign bus2.mem_wdata = wd[2];
  assign bus2.mem_we    = we[2];
  assign rdy[2] = bus2.mem_ready;
  assign rd[2]  = bus2.mem_rdata;
  assign er[2]  = bus2.mem_err;

  imem_responder #(.DEPTH_WORDS(4096), .WAIT_STATES(0), .BASE_ADDR(32'h0))
    u0 (.clk(clk), .rst_n(rst_n), .mem(bus0));
  imem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(1), .BASE_ADDR(32'h0))
    u1 (.clk(clk), .rst_n(rst_n), .mem(bus1));
  imem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2), .BASE_ADDR(32'h0))
    u2 (.clk(clk), .rst_n(rst_n), .mem(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One transaction on instance k; assumes the instance is IDLE or in RESP on entry.
  task automatic req(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wen, output logic [31:0] rdata,
                     output logic err, output int lat);
    v[k] = 1'b1; a[k] = addr; wd[k] = wdata; we[k] = wen;
    @(posedge clk); #1;
    v[k] = 1'b0; we[k] = 4'h0;
    lat = 0;
    while (!rdy[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rd[k];
    err   = er[k];
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      total++; if (rdy[k] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=0", k, rdy[k]); end
      total++; if (rd[k] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d] got=%h exp=00000000", k, rd[k]); end
      total++; if (er[k] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got=%b exp=0", k, er[k]); end
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL post_reset_ready got=%b exp=0", rdy[0]); end
  endtask

  task automatic preload();
    logic [31:0] d; logic e; int l;
    for (int k = 0; k < 3; k++) begin
      req(k, 32'h0, 32'h00000013, 4'hF, d, e, l);
      req(k, 32'h4, 32'h00100093, 4'hF, d, e, l);
      req(k, 32'h8, 32'h00200113, 4'hF, d, e, l);
    end
    req(0, 32'h10, 32'h11223344, 4'hF, d, e, l);
    req(2, 32'h14, 32'h55555555, 4'hF, d, e, l);
  endtask

  task automatic test_stream();
    logic [31:0] prog [3];
    prog[0] = 32'h00000013; prog[1] = 32'h00100093; prog[2] = 32'h00200113;
    v[0] = 1'b1; a[0] = 32'h0; we[0] = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, rdy[0]); end
      total++; if (rd[0] !== prog[i]) begin bad++; $display("FAIL stream_rdata[%0d] got=%h exp=%h", i, rd[0], prog[i]); end
      if (rdy[0]) a[0] = 32'(4 * (i + 1));
    end
    v[0] = 1'b0;
    @(posedge clk); #1;
    total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL stream_idle_ready got=%b exp=0", rdy[0]); end
  endtask

  task automatic test_latency();
    v[2] = 1'b1; a[2] = 32'h8; we[2] = 4'h0;
    @(posedge clk); #1;
    v[2] = 1'b0; a[2] = 32'h0;
    total++; if (rdy[2] !== 1'b0) begin bad++; $display("FAIL lat_wait1 got=%b exp=0", rdy[2]); end
    @(posedge clk); #1;
    total++; if (rdy[2] !== 1'b0) begin bad++; $display("FAIL lat_wait2 got=%b exp=0", rdy[2]); end
    total++; if (rd[2] !== 32'h0) begin bad++; $display("FAIL lat_rdata_idle got=%h exp=00000000", rd[2]); end
    @(posedge clk); #1;
    total++; if (rdy[2] !== 1'b1) begin bad++; $display("FAIL lat_ready got=%b exp=1", rdy[2]); end
    total++; if (rd[2] !== 32'h00200113) begin bad++; $display("FAIL lat_rdata got=%h exp=00200113", rd[2]); end
    @(posedge clk); #1;
    total++; if (rdy[2] !== 1'b0) begin bad++; $display("FAIL lat_single_pulse got=%b exp=0", rdy[2]); end
  endtask

  task automatic test_byte_write();
    logic [31:0] d; logic e; int l;
    req(0, 32'h10, 32'hAABBCCDD, 4'b0011, d, e, l);
    total++; if (d !== 32'h11223344) begin bad++; $display("FAIL bw_prewrite got=%h exp=11223344", d); end
    total++; if (l !== 0) begin bad++; $display("FAIL bw_latency got=%0d exp=0", l); end
    req(0, 32'h10, 32'h0, 4'h0, d, e, l);
    total++; if (d !== 32'h1122CCDD) begin bad++; $display("FAIL bw_readback got=%h exp=1122ccdd", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL bw_err got=%b exp=0", e); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic e; int l;
    req(1, 32'h40, 32'h0, 4'h0, d, e, l);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_rd_err got=%b exp=1", e); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL oor_rd_rdata got=%h exp=00000000", d); end
    total++; if (l !== 1) begin bad++; $display("FAIL oor_rd_latency got=%0d exp=1", l); end
    req(1, 32'h44, 32'hDEADBEEF, 4'hF, d, e, l);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%b exp=1", e); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL oor_wr_rdata got=%h exp=00000000", d); end
    req(1, 32'h4, 32'h0, 4'h0, d, e, l);
    total++; if (d !== 32'h00100093) begin bad++; $display("FAIL oor_ram_intact got=%h exp=00100093", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL oor_inrange_err got=%b exp=0", e); end
    req(1, 32'h3C, 32'h0, 4'h0, d, e, l);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL oor_last_word_err got=%b exp=0", e); end
    req(0, 32'hFFFFFFFC, 32'h0, 4'h0, d, e, l);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_top_err got=%b exp=1", e); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL oor_top_rdata got=%h exp=00000000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [3];
    int j = 0;
    logic exp_rdy;
    prog[0] = 32'h00000013; prog[1] = 32'h00100093; prog[2] = 32'h00200113;
    v[1] = 1'b1; a[1] = 32'h0; we[1] = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_rdy = (i % 2 == 1);
      total++; if (rdy[1] !== exp_rdy) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, rdy[1], exp_rdy); end
      if (rdy[1]) begin
        total++; if (rd[1] !== prog[j]) begin bad++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", j, rd[1], prog[j]); end
        j++;
        if (j == 3) v[1] = 1'b0;
        else        a[1] = 32'(4 * j);
      end
    end
    v[1] = 1'b0;
    @(posedge clk); #1;
    total++; if (rdy[1] !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%b exp=0", rdy[1]); end
    total++; if (j !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", j); end
    v[1] = 1'b1; a[1] = 32'h8;
    @(posedge clk); #1;
    v[1] = 1'b0; a[1] = 32'h0;
    total++; if (rdy[1] !== 1'b0) begin bad++; $display("FAIL drop_wait got=%b exp=0", rdy[1]); end
    @(posedge clk); #1;
    total++; if (rdy[1] !== 1'b1) begin bad++; $display("FAIL drop_ready got=%b exp=1", rdy[1]); end
    total++; if (rd[1] !== 32'h00200113) begin bad++; $display("FAIL drop_rdata got=%h exp=00200113", rd[1]); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; logic e; int l;
    int stale = 0;
    v[0] = 1'b1; a[0] = 32'h0;  wd[0] = 32'hFFFFFFFF; we[0] = 4'hF;
    v[2] = 1'b1; a[2] = 32'h14; wd[2] = 32'h99999999; we[2] = 4'hF;
    @(posedge clk); #1;
    v[0] = 1'b0; we[0] = 4'h0;
    v[2] = 1'b0; we[2] = 4'h0;
    total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL abort_in_resp got=%b exp=1", rdy[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL abort_async_ready got=%b exp=0", rdy[0]); end
    total++; if (rd[0] !== 32'h0) begin bad++; $display("FAIL abort_async_rdata got=%h exp=00000000", rd[0]); end
    #10 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rdy[0] || rdy[2]) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL abort_stale_ready got=%0d exp=0", stale); end
    req(0, 32'h0, 32'h0, 4'h0, d, e, l);
    total++; if (d !== 32'h00000013) begin bad++; $display("FAIL abort_no_write_resp got=%h exp=00000013", d); end
    req(2, 32'h14, 32'h0, 4'h0, d, e, l);
    total++; if (d !== 32'h55555555) begin bad++; $display("FAIL abort_no_write_wait got=%h exp=55555555", d); end
    total++; if (l !== 2) begin bad++; $display("FAIL abort_latency got=%0d exp=2", l); end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0; a[k] = '0; wd[k] = '0; we[k] = '0;
    end
    test_reset();
    preload();
    test_stream();
    test_latency();
    test_byte_write();
    test_out_of_range();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
